// File: rtl/game_pkg.sv
// Shared game constants: keyboard scancodes, direction encodings and jump cooldown defaults.
package game_pkg;

  localparam logic [8:0] SC_A = 9'h01C;
  localparam logic [8:0] SC_D = 9'h023;
  localparam logic [8:0] SC_W = 9'h01D;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  localparam int unsigned COOLDOWN_CYC_DEFAULT = 1_000_000;
  localparam int          CD_W                 = 20;

  // State encoding doubles as the dir output value.
  typedef enum logic [1:0] {
    ST_IDLE  = DIR_NONE,
    ST_RIGHT = DIR_RIGHT,
    ST_LEFT  = DIR_LEFT
  } dir_state_e;

endpackage

// File: rtl/cooldown_timer.sv
// Loadable down-counter that saturates at zero; zero is high whenever no cooldown is running.
module cooldown_timer
  import game_pkg::*;
#(
  parameter int unsigned LOAD_VAL = COOLDOWN_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam logic [CD_W-1:0] LOAD_CNT = CD_W'(LOAD_VAL);

  logic [CD_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_CNT;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/key_cmd_ctrl.sv
// Turns keyboard decoder events into a held movement direction and a handshaked,
// rate-limited jump request.
module key_cmd_ctrl
  import game_pkg::*;
#(
  parameter logic [8:0]  KEY_LEFT     = SC_A,
  parameter logic [8:0]  KEY_RIGHT    = SC_D,
  parameter logic [8:0]  KEY_JUMP     = SC_W,
  parameter int unsigned COOLDOWN_CYC = COOLDOWN_CYC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  output logic [1:0]   dir,
  output logic         jump_req,
  input  logic         jump_ack
);

  dir_state_e state_q, state_d;
  logic       w_held_q, w_held_d;
  logic       jump_req_q, jump_req_d;
  logic       cd_zero;
  logic       jump_evt;
  logic       jump_accept;

  always_comb begin
    state_d = state_q;
    if (key_valid) begin
      if (last_change == KEY_LEFT) begin
        if (key_down[KEY_LEFT]) begin
          state_d = ST_LEFT;
        end else if (state_q == ST_LEFT) begin
          state_d = key_down[KEY_RIGHT] ? ST_RIGHT : ST_IDLE;
        end
      end else if (last_change == KEY_RIGHT) begin
        if (key_down[KEY_RIGHT]) begin
          state_d = ST_RIGHT;
        end else if (state_q == ST_RIGHT) begin
          state_d = key_down[KEY_LEFT] ? ST_LEFT : ST_IDLE;
        end
      end
    end
  end

  // A jump make is only honoured on a fresh press with nothing pending and no cooldown.
  assign jump_evt    = key_valid && (last_change == KEY_JUMP);
  assign jump_accept = jump_evt && key_down[KEY_JUMP] && !w_held_q && !jump_req_q && cd_zero;

  always_comb begin
    w_held_d   = jump_evt ? key_down[KEY_JUMP] : w_held_q;
    jump_req_d = jump_req_q;
    if (jump_accept) begin
      jump_req_d = 1'b1;
    end else if (jump_ack) begin
      jump_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      w_held_q   <= 1'b0;
      jump_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_held_q   <= w_held_d;
      jump_req_q <= jump_req_d;
    end
  end

  cooldown_timer #(
    .LOAD_VAL (COOLDOWN_CYC)
  ) u_cooldown (
    .clk  (clk),
    .rst  (rst),
    .load (jump_accept),
    .zero (cd_zero)
  );

  assign dir      = state_q;
  assign jump_req = jump_req_q;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Scoreboard bench for key_cmd_ctrl: directed scenarios plus random decoder events
// checked against a timestamp-based reference model.
module tb_key_cmd_ctrl;
  import game_pkg::*;

  localparam int CD = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         jump_ack;
  logic [1:0]   dir;
  logic         jump_req;

  key_cmd_ctrl #(
    .KEY_LEFT     (SC_A),
    .KEY_RIGHT    (SC_D),
    .KEY_JUMP     (SC_W),
    .COOLDOWN_CYC (CD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .dir         (dir),
    .jump_req    (jump_req),
    .jump_ack    (jump_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] dir;
    logic       jreq;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model: direction = most recently pressed of the held A/D keys;
  // a jump is accepted on a fresh W press when idle and more than CD cycles
  // have passed since the previous accepted jump.
  int now;
  int stamp_l, stamp_r;
  bit m_wheld, m_jreq, have_acc;
  int last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      @(negedge clk);
      check("sb_dir", {30'd0, dir}, {30'd0, mon_e.dir});
      check("sb_jreq", {31'd0, jump_req}, {31'd0, mon_e.jreq});
    end
  end

  function automatic logic [1:0] model_dir();
    bit hl, hr;
    hl = key_down[SC_A];
    hr = key_down[SC_D];
    if (hl && (!hr || stamp_l > stamp_r)) return DIR_LEFT;
    if (hr) return DIR_RIGHT;
    return DIR_NONE;
  endfunction

  task automatic model_reset();
    now = 0; stamp_l = -1; stamp_r = -1;
    m_wheld = 0; m_jreq = 0; have_acc = 0; last_acc = 0;
  endtask

  // One clock cycle of stimulus; called and returns at posedge+1.
  task automatic cycle(input bit v, input logic [8:0] code, input bit mk, input bit ack);
    bit acc;
    if (v) key_down[code] = mk;
    key_valid   = v;
    last_change = code;
    jump_ack    = ack;
    acc = v && (code == SC_W) && mk && !m_wheld && !m_jreq &&
          (!have_acc || (now - last_acc) > CD);
    if (v && code == SC_A && mk) stamp_l = now;
    if (v && code == SC_D && mk) stamp_r = now;
    if (v && code == SC_W) m_wheld = mk;
    if (acc) begin
      m_jreq = 1; have_acc = 1; last_acc = now;
    end else if (ack) begin
      m_jreq = 0;
    end
    sb_q.push_back({model_dir(), m_jreq});
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    jump_ack  = 1'b0;
    now++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_dir", {30'd0, dir}, 32'd0);
    check("rst_async_jreq", {31'd0, jump_req}, 32'd0);
    key_down = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int rises;
  bit prev_j;
  logic [8:0] rcode;
  int rsel;

  initial begin
    rst = 1'b1; key_down = '0; last_change = '0; key_valid = 1'b0; jump_ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_dir", {30'd0, dir}, 32'd0);
    check("reset_jreq", {31'd0, jump_req}, 32'd0);
    rst = 1'b0;

    // Make A / break A
    cycle(1, SC_A, 1, 0);
    $display("s1 make A      dir=%b", dir);
    check("s1_make_a", {30'd0, dir}, {30'd0, DIR_LEFT});
    cycle(1, SC_A, 0, 0);
    $display("s1 break A     dir=%b", dir);
    check("s1_break_a", {30'd0, dir}, {30'd0, DIR_NONE});

    // Make A, make D, break D with A held
    cycle(1, SC_A, 1, 0);
    check("s2_make_a", {30'd0, dir}, {30'd0, DIR_LEFT});
    cycle(1, SC_D, 1, 0);
    check("s2_make_d", {30'd0, dir}, {30'd0, DIR_RIGHT});
    cycle(1, SC_D, 0, 0);
    $display("s2 break D     dir=%b", dir);
    check("s2_break_d", {30'd0, dir}, {30'd0, DIR_LEFT});
    cycle(1, SC_A, 0, 0);

    // Jump held 50 cycles without ack
    do_reset();
    cycle(1, SC_W, 1, 0);
    check("s3_rise", {31'd0, jump_req}, 32'd1);
    for (int i = 0; i < 50; i++) begin
      idle(1);
      check("s3_hold", {31'd0, jump_req}, 32'd1);
    end
    cycle(0, 9'h000, 0, 1);
    $display("s3 ack         jump_req=%b", jump_req);
    check("s3_ack", {31'd0, jump_req}, 32'd0);
    cycle(1, SC_W, 0, 0);

    // Second make inside cooldown is dropped
    do_reset();
    cycle(1, SC_W, 1, 0);
    idle(4);
    cycle(0, 9'h000, 0, 1);
    cycle(1, SC_W, 0, 0);
    idle(93);
    cycle(1, SC_W, 1, 0);
    $display("s4 make@100    jump_req=%b", jump_req);
    check("s4_cd_reject", {31'd0, jump_req}, 32'd0);
    idle(2);
    check("s4_cd_still0", {31'd0, jump_req}, 32'd0);
    cycle(1, SC_W, 0, 0);

    // Second make after cooldown is accepted
    do_reset();
    cycle(1, SC_W, 1, 0);
    idle(4);
    cycle(0, 9'h000, 0, 1);
    cycle(1, SC_W, 0, 0);
    idle(1193);
    cycle(1, SC_W, 1, 0);
    $display("s5 make@1200   jump_req=%b", jump_req);
    check("s5_cd_accept", {31'd0, jump_req}, 32'd1);
    cycle(0, 9'h000, 0, 1);
    cycle(1, SC_W, 0, 0);

    // Cooldown boundary: make at +CD rejected, make at +CD+2 accepted
    do_reset();
    cycle(1, SC_W, 1, 0);
    cycle(0, 9'h000, 0, 1);
    cycle(1, SC_W, 0, 0);
    idle(997);
    cycle(1, SC_W, 1, 0);
    check("s5b_edge_reject", {31'd0, jump_req}, 32'd0);
    cycle(1, SC_W, 0, 0);
    cycle(1, SC_W, 1, 0);
    $display("s5b make@1002  jump_req=%b", jump_req);
    check("s5b_edge_accept", {31'd0, jump_req}, 32'd1);
    cycle(0, 9'h000, 0, 1);
    cycle(1, SC_W, 0, 0);

    // Typematic repeats give one rise
    do_reset();
    rises = 0; prev_j = 0;
    for (int i = 0; i < 11; i++) begin
      cycle(1, SC_W, 1, 0);
      if (jump_req && !prev_j) rises++;
      prev_j = jump_req;
      idle(1);
      if (jump_req && !prev_j) rises++;
      prev_j = jump_req;
    end
    $display("s6 repeats     rises=%0d", rises);
    check("s6_one_rise", rises, 32'd1);
    cycle(1, SC_W, 0, 0);

    // Async reset while requesting and moving right
    do_reset();
    cycle(1, SC_D, 1, 0);
    cycle(1, SC_W, 1, 0);
    check("s7_pre_dir", {30'd0, dir}, {30'd0, DIR_RIGHT});
    check("s7_pre_jreq", {31'd0, jump_req}, 32'd1);
    do_reset();
    $display("s7 reset       dir=%b jump_req=%b", dir, jump_req);

    // Random decoder traffic
    for (int i = 0; i < 2500; i++) begin
      rsel = $urandom_range(0, 9);
      if (rsel < 3)      rcode = SC_A;
      else if (rsel < 6) rcode = SC_D;
      else if (rsel < 8) rcode = SC_W;
      else begin
        rcode = 9'($urandom());
        if (rcode == SC_A || rcode == SC_D || rcode == SC_W) rcode = 9'h1FF;
      end
      cycle(1'($urandom_range(0, 1)), rcode, ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) == 0));
    end

    idle(2);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_cmd_ctrl.md
KEY_CMD_CTRL -- requirements
Module: key_cmd_ctrl

Interface
REQ-001 Parameter KEY_LEFT, default 9'h01C, make code of the left key (A).
REQ-002 Parameter KEY_RIGHT, default 9'h023, make code of the right key (D).
REQ-003 Parameter KEY_JUMP, default 9'h01D, make code of the jump key (W).
REQ-004 Parameter COOLDOWN_CYC, default 1_000_000, minimum clk cycles between accepted jumps; 20-bit range.
REQ-005 Port clk, input, 1, system clock; single clock domain.
REQ-006 Port rst, input, 1, reset, asynchronous, active-high.
REQ-007 Port key_down, input, 512, per-scancode held flags from the keyboard decoder.
REQ-008 Port last_change, input, 9, scancode of the most recent decoder event.
REQ-009 Port key_valid, input, 1, one-cycle strobe; last_change and key_down are valid this cycle.
REQ-010 Port dir, output, 2, held direction: 2'b00 none, 2'b01 right, 2'b10 left; registered.
REQ-011 Port jump_req, output, 1, jump request, held high until acknowledged.
REQ-012 Port jump_ack, input, 1, one-cycle acknowledge from the slime motion stage.

Function
REQ-013 Direction FSM SHALL have states IDLE, LEFT, RIGHT; dir SHALL equal the state encoding (IDLE=00, RIGHT=01, LEFT=10).
REQ-014 FSM SHALL change state only in a cycle with key_valid=1; dir SHALL update on the next clk edge, a 1-cycle latency.
REQ-015 Make of KEY_LEFT (key_down[KEY_LEFT]=1) SHALL go to LEFT from any state; make of KEY_RIGHT SHALL go to RIGHT from any state; the last-pressed key wins.
REQ-016 Break of the active key SHALL go to the other direction if its key_down bit is 1, else to IDLE.
REQ-017 Break of the inactive direction key SHALL leave the state unchanged.
REQ-018 Typematic repeats (make of an already-active key) SHALL leave the state unchanged.
REQ-019 key_valid with any other scancode SHALL leave the state unchanged.
REQ-020 Block SHALL keep w_held, set on KEY_JUMP make and cleared on KEY_JUMP break.
REQ-021 A KEY_JUMP make is accepted only if w_held=0, jump_req=0 and cooldown=0; jump_req SHALL rise one cycle after the accepting key_valid.
REQ-022 A 20-bit cooldown counter SHALL load COOLDOWN_CYC in the cycle jump_req rises, then decrement by 1 per cycle and saturate at 0.
REQ-023 jump_req SHALL clear on the clk edge after a cycle with jump_ack=1; jump_ack while jump_req=0 SHALL be ignored.
REQ-024 A rejected jump make SHALL be dropped, not queued; this covers repeats, pending requests and active cooldown.
REQ-025 If jump_ack and an accepted-eligible KEY_JUMP make arrive in the same cycle, the make SHALL be rejected, because jump_req=1 in that cycle.
REQ-026 Direction and jump logic SHALL be independent; a jump event SHALL NOT alter dir.

Reset
REQ-027 While rst=1: dir=2'b00, state IDLE, jump_req=0, w_held=0, cooldown=0, asynchronously.
REQ-028 Reset asserted mid-request SHALL drop any pending jump_req with no acknowledge required.
REQ-029 After rst falls, the first key_valid SHALL be processed normally; keys held across reset count as held only after their next decoder event.

Structure
REQ-030 Shared package game_pkg SHALL hold the scancode constants, the DIR_NONE/DIR_RIGHT/DIR_LEFT encodings and the default COOLDOWN_CYC.
REQ-031 The cooldown counter SHALL be the single sub-module cooldown_timer, with ports clk, rst, load, and zero.
REQ-032 key_cmd_ctrl SHALL replace the inline key_state register in the top level and feed slime_move.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Make A, then break A: dir=10 one cycle after the make, dir=00 one cycle after the break.
- Make A, make D, break D with A still held: dir goes 10, then 01, then 10.
- Make W: jump_req=1 next cycle and stays high for 50 cycles with no ack; ack pulse gives jump_req=0 next cycle.
- Make W at cycle 0, ack at cycle 5, break W, make W at cycle 100 with COOLDOWN_CYC=1000: jump_req stays 0.
- Same sequence with the second make at cycle 1200: jump_req=1.
- Make W followed by 10 typematic repeats: exactly one jump_req rise.
- rst asserted while jump_req=1 and dir=01: jump_req=0 and dir=00 immediately, before the next clk edge.
